term_bus_capture: RTL and testbench



---
 rtl/term_capture_pkg.sv | 16 +
 rtl/term_skid_buf.sv | 73 +++++++
 rtl/term_bus_capture.sv | 115 +++++++++++
 tb/tb_term_bus_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_capture_pkg.sv
// Shared types and helpers for the terminal bus capture block.
package term_capture_pkg;

  localparam int unsigned BUS_W = 32;
  localparam logic [BUS_W-1:0] DEFAULT_CONNECT_MASK = 32'h7FEF7FFE;

  typedef enum logic [1:0] {CAP_EMPTY, CAP_ONE, CAP_TWO} cap_state_e;

  // Connected lanes pass the port word; erased lanes take the fill value.
  function automatic logic [BUS_W-1:0] apply_mask(input logic [BUS_W-1:0] word,
                                                  input logic [BUS_W-1:0] mask,
                                                  input logic [BUS_W-1:0] fill);
    return (word & mask) | (fill & ~mask);
  endfunction

endpackage

// File: rtl/term_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready and out_valid are registered state decodes.
module term_skid_buf
  import term_capture_pkg::*;
#(
  parameter int unsigned   DW        = 32,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  cap_state_e    state_q;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          valid_q;
  logic          ready_q;

  // in_ready is high in EMPTY and ONE, so in_valid_i alone means an accept there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CAP_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        CAP_EMPTY: begin
          if (in_valid_i) begin
            main_q  <= in_data_i;
            state_q <= CAP_ONE;
            valid_q <= 1'b1;
          end
        end
        CAP_ONE: begin
          if (in_valid_i && out_ready_i) begin
            main_q <= in_data_i;
          end else if (in_valid_i) begin
            skid_q  <= in_data_i;
            state_q <= CAP_TWO;
            ready_q <= 1'b0;
          end else if (out_ready_i) begin
            state_q <= CAP_EMPTY;
            valid_q <= 1'b0;
          end
        end
        CAP_TWO: begin
          if (out_ready_i) begin
            main_q  <= skid_q;
            state_q <= CAP_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= CAP_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/term_bus_capture.sv
// Masked capture of a partially connected port bus with erased-lane activity monitor.
// Optional TERM_CAPTURE_PARITY_EN adds out_parity_o carried through the skid buffer.
module term_bus_capture
  import term_capture_pkg::*;
#(
  parameter int unsigned      WIDTH        = BUS_W,
  parameter logic [WIDTH-1:0] CONNECT_MASK = DEFAULT_CONNECT_MASK,
  parameter logic [WIDTH-1:0] FILL_VALUE   = '0,
  parameter int unsigned      CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_term_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_net_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             erased_toggle_o,
  input  logic             clr_sticky_i,
  output logic [CNT_W-1:0] word_cnt_o
`ifdef TERM_CAPTURE_PARITY_EN
  ,
  output logic             out_parity_o
`endif
);

  localparam logic [WIDTH-1:0] ERASE_MASK = ~CONNECT_MASK;
  localparam bit               HasErased  = |ERASE_MASK;

  logic [WIDTH-1:0] masked;
  logic             accept;

  assign masked = apply_mask(in_term_i, CONNECT_MASK, FILL_VALUE);
  assign accept = in_valid_i & in_ready_o;

`ifdef TERM_CAPTURE_PARITY_EN
  localparam int unsigned PW = WIDTH + 1;
`else
  localparam int unsigned PW = WIDTH;
`endif

  logic [PW-1:0] payload;
  logic [PW-1:0] buf_data;

`ifdef TERM_CAPTURE_PARITY_EN
  // Parity travels with the word so it can never lag out_net_o.
  assign payload      = {^(masked & CONNECT_MASK), masked};
  assign out_net_o    = buf_data[WIDTH-1:0];
  assign out_parity_o = buf_data[WIDTH];
`else
  assign payload   = masked;
  assign out_net_o = buf_data;
`endif

  term_skid_buf #(
    .DW        (PW),
    .RESET_VAL (PW'(FILL_VALUE))
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (payload),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (buf_data),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  logic [WIDTH-1:0] snap_q, snap_d;
  logic             snap_vld_q, snap_vld_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] erased_bits;
  logic             toggle_set;

  assign erased_bits = in_term_i & ERASE_MASK;
  // First accept after reset only primes the snapshot.
  assign toggle_set  = HasErased && accept && snap_vld_q && (erased_bits != snap_q);

  always_comb begin
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    if (accept) begin
      snap_d     = erased_bits;
      snap_vld_d = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
    end
    if (toggle_set) begin
      sticky_d = 1'b1;
    end else if (clr_sticky_i) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign erased_toggle_o = sticky_q;
  assign word_cnt_o      = cnt_q;

endmodule

// File: tb/tb_term_bus_capture.sv
// Scoreboard bench for term_bus_capture: lane-level reference model, queue-based delivery check.
module tb_term_bus_capture;

  localparam int CW = 4;
  localparam logic [31:0] FILL = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   in_term = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   out_net;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          erased_toggle;
  logic          clr_sticky = 1'b0;
  logic [CW-1:0] word_cnt;
`ifdef TERM_CAPTURE_PARITY_EN
  logic          out_parity;
`endif

  term_bus_capture #(
    .CNT_W (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_term_i       (in_term),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .out_net_o       (out_net),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .erased_toggle_o (erased_toggle),
    .clr_sticky_i    (clr_sticky),
    .word_cnt_o      (word_cnt)
`ifdef TERM_CAPTURE_PARITY_EN
    ,
    .out_parity_o    (out_parity)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  int          occ = 0;
  int unsigned exp_cnt = 0;
  bit          exp_tog = 1'b0;
  bit          snap_vld = 1'b0;
  logic [31:0] snap = '0;
  int          erased_lanes[4] = '{0, 15, 20, 31};

  function automatic bit is_erased(input int lane);
    foreach (erased_lanes[k]) if (erased_lanes[k] == lane) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_mask(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = is_erased(i) ? FILL[i] : w[i];
    return r;
  endfunction

  function automatic logic [31:0] erased_of(input logic [31:0] w);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) if (is_erased(i)) r[i] = w[i];
    return r;
  endfunction

  function automatic bit parity_of(input logic [31:0] w);
    int n = 0;
    for (int i = 0; i < 32; i++) if (!is_erased(i) && w[i]) n++;
    return bit'(n % 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: handshake bookkeeping, counter, sticky flag
  always @(negedge clk) begin : model
    bit acc;
    bit dlv;
    bit set;
    logic [31:0] e;
    if (rst_n) begin
      check("out_valid", 64'(out_valid), 64'(occ > 0));
      check("in_ready", 64'(in_ready), 64'(occ < 2));
      check("word_cnt", 64'(word_cnt), 64'(exp_cnt));
      check("erased_toggle", 64'(erased_toggle), 64'(exp_tog));
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      set = 1'b0;
      if (acc) begin
        exp_q.push_back(model_mask(in_term));
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        e = erased_of(in_term);
        set = snap_vld && (e != snap);
        snap = e;
        snap_vld = 1'b1;
      end
      if (set) exp_tog = 1'b1;
      else if (clr_sticky) exp_tog = 1'b0;
      occ = occ + int'(acc) - int'(dlv);
    end
  end

  // Monitor: compares each delivered word against the scoreboard
  always @(negedge clk) begin : monitor
    logic [31:0] w;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(out_net), 64'hDEAD_0000_0000_0000);
      end else begin
        w = exp_q.pop_front();
        check("out_net", 64'(out_net), 64'(w));
`ifdef TERM_CAPTURE_PARITY_EN
        check("out_parity", 64'(out_parity), 64'(parity_of(w)));
`endif
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    occ = 0;
    exp_cnt = 0;
    exp_tog = 1'b0;
    snap_vld = 1'b0;
    snap = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr_sticky = 1'b0;
    model_reset();
    #13;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit ordy, input bit clr);
    int n = 0;
    bit acc = 1'b0;
    in_term = d;
    in_valid = 1'b1;
    out_ready = ordy;
    clr_sticky = clr;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      clr_sticky = 1'b0;
      if (!acc) begin
        out_ready = 1'b1;
        n++;
        if (n > 50) begin
          check("accept_timeout", 64'(n), 64'(0));
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit ordy);
    in_valid = 1'b0;
    out_ready = ordy;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
  endtask

  logic [31:0] erased_keep;
  logic [31:0] d;

  initial begin
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_net", 64'(out_net), 64'(FILL));
    check("rst_toggle", 64'(erased_toggle), 64'(0));
    check("rst_word_cnt", 64'(word_cnt), 64'(0));

    send(32'hFFFF_FFFF, 1'b1, 1'b0);
    check("single_out_net", 64'(out_net), 64'h7FEF_7FFE);
    check("single_valid", 64'(out_valid), 64'(1));
    check("single_cnt", 64'(word_cnt), 64'(1));
    idle(2, 1'b1);

    send(32'h1111_1111, 1'b0, 1'b0);
    send(32'h2222_2222, 1'b0, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_head", 64'(out_net), 64'h1101_1110);
    idle(4, 1'b1);
    check("bp_drained", 64'(out_valid), 64'(0));

    send(32'h0000_0000, 1'b1, 1'b0);
    pulse_clr();
    check("tog_cleared0", 64'(erased_toggle), 64'(0));
    send(32'h0010_0000, 1'b1, 1'b0);
    check("tog_set_bit20", 64'(erased_toggle), 64'(1));
    pulse_clr();
    check("tog_cleared1", 64'(erased_toggle), 64'(0));
    send(32'h0010_0020, 1'b1, 1'b0);
    check("tog_conn_lane", 64'(erased_toggle), 64'(0));
    send(32'h0000_0020, 1'b1, 1'b1);
    check("tog_set_wins", 64'(erased_toggle), 64'(1));

    send(32'h0000_0003, 1'b1, 1'b0);
    send(32'h0000_0002, 1'b1, 1'b0);
    send(32'h0000_0001, 1'b1, 1'b0);
    idle(2, 1'b1);

    do_reset();
    repeat (17) send($urandom, 1'b1, 1'b0);
    check("cnt_wrap", 64'(word_cnt), 64'(1));
    idle(3, 1'b1);

    send(32'hAAAA_5555, 1'b0, 1'b0);
    send(32'h5555_AAAA, 1'b0, 1'b0);
    check("two_full", 64'(in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'(0));
    check("async_in_ready", 64'(in_ready), 64'(1));
    check("async_out_net", 64'(out_net), 64'(FILL));
    check("async_cnt", 64'(word_cnt), 64'(0));
    model_reset();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    erased_keep = $urandom;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) erased_keep = $urandom;
      d = ($urandom & 32'h7FEF_7FFE) | (erased_keep & 32'h8010_8001);
      if ($urandom_range(2) != 0) send(d, 1'(($urandom_range(3)) != 0), 1'($urandom_range(7) == 0));
      else idle(1, 1'($urandom_range(1)));
    end
    idle(6, 1'b1);
    check("final_drained", 64'(out_valid), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
